serial_link_scheduler: RTL and testbench

Arbitrating front end for the one-wire board-to-board serial link. Up to NUM_REQ sources (switch bank, DDS tuning words, status) each offer one WORD_W-bit word. On each trigger rising edge the block grants one pending source round-robin, waits a setup interval with dflag low, then shifts the word out LSB-first with dflag high, followed by an enforced inter-frame gap. It sits between the word sources and the board output pins and replaces free-running per-source senders.

---
 rtl/serial_link_scheduler.sv | 178 +++++++++++++++++
 tb/tb_serial_link_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_link_scheduler.sv
// Round-robin arbiter and one-wire serial framer: grants one requester per trigger edge, then setup, payload, gap.
// Optional even-parity trailer bit when SERIAL_SCHED_PARITY_EN is defined.
module serial_link_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int WORD_W       = 18,
    parameter int SETUP_CYCLES = 1000,
    parameter int GAP_CYCLES   = 1000
) (
    input  logic                        Ten_MHz_input,
    input  logic                        reset_n,
    input  logic                        trigger,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*WORD_W-1:0]   words,
    output logic [NUM_REQ-1:0]          ack,
    output logic                        data_out_1_bit,
    output logic                        dflag,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  active_id,
    output logic                        overrun
);
    localparam int ID_W    = $clog2(NUM_REQ);
    localparam int MAX_A   = (SETUP_CYCLES > GAP_CYCLES) ? SETUP_CYCLES : GAP_CYCLES;
    localparam int CNT_MAX = (MAX_A > WORD_W) ? MAX_A : WORD_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, SETUP, SEND, PAR, GAP} state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [WORD_W-1:0]   shift_reg, shift_next;
    logic [ID_W-1:0]     last_grant_reg, last_grant_next;
    logic [ID_W-1:0]     active_id_reg, active_id_next;
    logic [NUM_REQ-1:0]  ack_reg, ack_next;
    logic                data_reg, data_next;
    logic                dflag_reg, dflag_next;
    logic                busy_reg;
    logic                overrun_reg, overrun_next;
    logic [2:0]          sync_reg;
    logic                trig_edge;
    logic                grant_found;
    logic [ID_W-1:0]     grant_id;
    int                  cand;
`ifdef SERIAL_SCHED_PARITY_EN
    logic                parity_reg, parity_next;
`endif

    logic [WORD_W-1:0] word_arr [NUM_REQ];
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_word
        assign word_arr[gi] = words[gi*WORD_W +: WORD_W];
    end

    assign trig_edge = sync_reg[1] & ~sync_reg[2];

    // Descending scan so the candidate closest after last_grant is assigned last and wins.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = int'(last_grant_reg) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (req[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        shift_next      = shift_reg;
        last_grant_next = last_grant_reg;
        active_id_next  = active_id_reg;
        ack_next        = '0;
        data_next       = 1'b0;
        dflag_next      = 1'b0;
        overrun_next    = 1'b0;
`ifdef SERIAL_SCHED_PARITY_EN
        parity_next     = parity_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (trig_edge && grant_found) begin
                    state_next         = SETUP;
                    cnt_next           = CNT_W'(SETUP_CYCLES - 1);
                    shift_next         = word_arr[grant_id];
                    active_id_next     = grant_id;
                    last_grant_next    = grant_id;
                    ack_next[grant_id] = 1'b1;
`ifdef SERIAL_SCHED_PARITY_EN
                    parity_next        = ^word_arr[grant_id];
`endif
                end
            end
            SETUP: begin
                if (cnt_reg == '0) begin
                    state_next = SEND;
                    cnt_next   = CNT_W'(WORD_W - 1);
                    data_next  = shift_reg[0];
                    dflag_next = 1'b1;
                    shift_next = shift_reg >> 1;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            SEND: begin
                if (cnt_reg == '0) begin
`ifdef SERIAL_SCHED_PARITY_EN
                    state_next = PAR;
                    data_next  = parity_reg;
                    dflag_next = 1'b1;
`else
                    state_next = GAP;
                    cnt_next   = CNT_W'(GAP_CYCLES - 1);
`endif
                end else begin
                    data_next  = shift_reg[0];
                    dflag_next = 1'b1;
                    shift_next = shift_reg >> 1;
                    cnt_next   = cnt_reg - CNT_W'(1);
                end
            end
            PAR: begin
                state_next = GAP;
                cnt_next   = CNT_W'(GAP_CYCLES - 1);
            end
            GAP: begin
                if (cnt_reg == '0) state_next = IDLE;
                else               cnt_next   = cnt_reg - CNT_W'(1);
            end
            default: state_next = IDLE;
        endcase
        // Edges arriving while a frame is in flight are reported and discarded.
        if (trig_edge && state_reg != IDLE) overrun_next = 1'b1;
    end

    always_ff @(posedge Ten_MHz_input or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            shift_reg      <= '0;
            last_grant_reg <= ID_W'(NUM_REQ - 1);
            active_id_reg  <= '0;
            ack_reg        <= '0;
            data_reg       <= 1'b0;
            dflag_reg      <= 1'b0;
            busy_reg       <= 1'b0;
            overrun_reg    <= 1'b0;
            sync_reg       <= '0;
`ifdef SERIAL_SCHED_PARITY_EN
            parity_reg     <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            shift_reg      <= shift_next;
            last_grant_reg <= last_grant_next;
            active_id_reg  <= active_id_next;
            ack_reg        <= ack_next;
            data_reg       <= data_next;
            dflag_reg      <= dflag_next;
            busy_reg       <= (state_next != IDLE);
            overrun_reg    <= overrun_next;
            sync_reg       <= {sync_reg[1:0], trigger};
`ifdef SERIAL_SCHED_PARITY_EN
            parity_reg     <= parity_next;
`endif
        end
    end

    assign ack            = ack_reg;
    assign data_out_1_bit = data_reg;
    assign dflag          = dflag_reg;
    assign busy           = busy_reg;
    assign active_id      = active_id_reg;
    assign overrun        = overrun_reg;
endmodule

// File: tb/tb_serial_link_scheduler.sv
// Self-checking bench for serial_link_scheduler: vector table of frames plus overrun, gap and reset sequences.
`timescale 1ns/1ps
module tb_serial_link_scheduler;
    localparam int NUM_REQ = 4;
    localparam int WORD_W  = 18;
    localparam int SETUP   = 1000;
    localparam int GAP     = 1000;
`ifdef SERIAL_SCHED_PARITY_EN
    localparam int FRAME_LEN = WORD_W + 1;
`else
    localparam int FRAME_LEN = WORD_W;
`endif
    localparam int IDLE_BUDGET = SETUP + FRAME_LEN + GAP + 50;

    logic                      clk = 1'b0;
    logic                      reset_n = 1'b0;
    logic                      trigger = 1'b0;
    logic [NUM_REQ-1:0]        req = '0;
    logic [NUM_REQ*WORD_W-1:0] words = '0;
    logic [NUM_REQ-1:0]        ack;
    logic                      data_out_1_bit;
    logic                      dflag;
    logic                      busy;
    logic [1:0]                active_id;
    logic                      overrun;

    serial_link_scheduler #(.NUM_REQ(NUM_REQ), .WORD_W(WORD_W),
                            .SETUP_CYCLES(SETUP), .GAP_CYCLES(GAP)) dut (
        .Ten_MHz_input(clk), .reset_n(reset_n), .trigger(trigger), .req(req),
        .words(words), .ack(ack), .data_out_1_bit(data_out_1_bit), .dflag(dflag),
        .busy(busy), .active_id(active_id), .overrun(overrun));

    always #50 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_id_q[$];
    logic exp_bit_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Scoreboard monitor: pops expected grant on ack, expected bit on every dflag cycle.
    int cyc = 0;
    int ack_cyc = 0;
    int run = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            run = 0;
        end else begin
            cyc++;
            if (|ack) begin
                if (exp_id_q.size() == 0) begin
                    chk("unexpected_ack", 32'(ack), 32'd0);
                end else begin
                    int id;
                    id = exp_id_q.pop_front();
                    chk("ack_onehot", 32'(ack), 32'(1 << id));
                    chk("active_id_on_ack", 32'(active_id), 32'(id));
                    $display("grant id=%0d ack=%b", id, ack);
                end
                ack_cyc = cyc;
            end
            if (dflag) begin
                if (run == 0) chk("setup_latency", 32'(cyc - ack_cyc), 32'(SETUP));
                if (exp_bit_q.size() == 0) begin
                    chk("unexpected_bit", 32'd1, 32'd0);
                end else begin
                    logic b;
                    b = exp_bit_q.pop_front();
                    chk($sformatf("bit%0d", run), 32'(data_out_1_bit), 32'(b));
                end
                run++;
            end else begin
                chk("data_idle", 32'(data_out_1_bit), 32'd0);
                if (run != 0) begin
                    chk("frame_len", 32'(run), 32'(FRAME_LEN));
                    run = 0;
                end
            end
        end
    end

    typedef struct {
        logic [NUM_REQ-1:0]        req;
        logic [NUM_REQ*WORD_W-1:0] words;
        int                        exp_id;
    } vec_t;
    vec_t vecs[9];

    task automatic push_frame(input logic [NUM_REQ*WORD_W-1:0] w, input int id);
        logic [WORD_W-1:0] word;
        word = w[id*WORD_W +: WORD_W];
        exp_id_q.push_back(id);
        for (int k = 0; k < WORD_W; k++) exp_bit_q.push_back(word[k]);
`ifdef SERIAL_SCHED_PARITY_EN
        exp_bit_q.push_back(^word);
`endif
    endtask

    task automatic pulse_trigger();
        @(negedge clk) trigger = 1'b1;
        repeat (2) @(negedge clk);
        trigger = 1'b0;
    endtask

    task automatic wait_level(input string name, input logic want_busy, input logic use_dflag,
                              input logic lvl, input int budget);
        int n;
        n = 0;
        while (((use_dflag ? dflag : busy) !== lvl) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(use_dflag ? dflag : busy), 32'(lvl));
        if (want_busy) ;
    endtask

    task automatic count_overrun(input string name, input int expn);
        int n;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (overrun) n++;
        end
        chk(name, 32'(n), 32'(expn));
    endtask

    task automatic run_frame(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ*WORD_W-1:0] w, input int id);
        @(negedge clk);
        req = r;
        words = w;
        push_frame(w, id);
        pulse_trigger();
        wait_level("busy_rise", 1'b1, 1'b0, 1'b1, 10);
        wait_level("busy_fall", 1'b1, 1'b0, 1'b0, IDLE_BUDGET);
        chk("active_id_hold", 32'(active_id), 32'(id));
        chk("bits_drained", 32'(exp_bit_q.size()), 32'd0);
        chk("grants_drained", 32'(exp_id_q.size()), 32'd0);
    endtask

    initial begin
        #(100 * 90000);
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NUM_REQ*WORD_W-1:0] wa, wb;
        wa = {18'h3F0F0, 18'h00003, 18'h00007, 18'h2A5C3};
        wb = {18'h12345, 18'h0ABCD, 18'h3FFFF, 18'h00000};
        vecs[0] = '{4'b1111, wa, 0};
        vecs[1] = '{4'b1111, wa, 1};
        vecs[2] = '{4'b1111, wa, 2};
        vecs[3] = '{4'b1111, wa, 3};
        vecs[4] = '{4'b1111, wa, 0};
        vecs[5] = '{4'b0001, wa, 0};
        vecs[6] = '{4'b0100, wb, 2};
        vecs[7] = '{4'b1010, wb, 3};
        vecs[8] = '{4'b0011, wb, 0};

        #20;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_dflag", 32'(dflag), 32'd0);
        chk("rst_data", 32'(data_out_1_bit), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_active_id", 32'(active_id), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int v = 0; v < 9; v++) begin
            run_frame(vecs[v].req, vecs[v].words, vecs[v].exp_id);
            $display("vector %0d req=%b id=%0d done", v, vecs[v].req, vecs[v].exp_id);
        end

        // Trigger with no requests: nothing happens
        req = '0;
        pulse_trigger();
        count_overrun("idle_noreq_overrun", 0);
        chk("idle_noreq_busy", 32'(busy), 32'd0);
        $display("no-request trigger ignored");

        // Second edge during SEND: one overrun pulse, frame intact
        req = 4'b0001;
        words = wa;
        push_frame(wa, 1 - 1 + 0);
        pulse_trigger();
        wait_level("dflag_rise_ovr", 1'b0, 1'b1, 1'b1, SETUP + 20);
        pulse_trigger();
        count_overrun("send_overrun", 1);
        wait_level("busy_fall_ovr", 1'b0, 1'b0, 1'b0, IDLE_BUDGET);
        chk("ovr_bits_drained", 32'(exp_bit_q.size()), 32'd0);
        $display("overrun during SEND sequence done");

        // Edge right after dflag falls lands in GAP: overrun, no grant
        req = 4'b0001;
        push_frame(wa, 0);
        pulse_trigger();
        wait_level("dflag_rise_gap", 1'b0, 1'b1, 1'b1, SETUP + 20);
        wait_level("dflag_fall_gap", 1'b0, 1'b1, 1'b0, FRAME_LEN + 5);
        pulse_trigger();
        count_overrun("gap_overrun", 1);
        chk("gap_still_busy", 32'(busy), 32'd1);
        wait_level("busy_fall_gap", 1'b0, 1'b0, 1'b0, IDLE_BUDGET);
        run_frame(4'b0100, wa, 2);
        $display("gap enforcement sequence done");

        // Reset at bit 7 of a frame granted to source 0
        run_frame(4'b0001, wa, 0);
        push_frame(wa, 0);
        pulse_trigger();
        wait_level("dflag_rise_rst", 1'b0, 1'b1, 1'b1, SETUP + 20);
        repeat (7) @(negedge clk);
        #5 reset_n = 1'b0;
        #1;
        chk("midrst_dflag", 32'(dflag), 32'd0);
        chk("midrst_data", 32'(data_out_1_bit), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ack", 32'(ack), 32'd0);
        chk("midrst_active_id", 32'(active_id), 32'd0);
        exp_bit_q.delete();
        exp_id_q.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        chk("postrst_busy", 32'(busy), 32'd0);
        run_frame(4'b0011, wb, 0);
        $display("reset mid-SEND sequence done");

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
